// File: rtl/vga_text_console.sv
// Text-mode VRAM writer: turns a character byte stream into glyph writes, tracks the cursor and scrolls.
// Optional macro TAB_EXPAND_EN makes 0x09 expand to spaces up to the next multiple-of-8 column.
module vga_text_console #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_waddr,
  output logic [DATA_W-1:0] vram_wdata,
  output logic [ADDR_W-1:0] vram_raddr,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] L_COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] L_LAST     = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] L_LAST_ROW = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [6:0]        L_COL_MAX  = 7'(COLS - 1);
  localparam logic [4:0]        L_ROW_MAX  = 5'(ROWS - 1);
  localparam logic [7:0]        L_SPACE    = 8'h20;

  typedef enum logic [2:0] {S_IDLE, S_PUT, S_SCROLL_RD, S_SCROLL_WR, S_CLEAR} state_t;

  state_t            r_state, w_state;
  logic [6:0]        r_col, w_col;
  logic [4:0]        r_row, w_row;
  logic [7:0]        r_ch, w_ch;
  logic              r_putWr, w_putWr;
  logic              r_putAdv, w_putAdv;
  logic              r_putTab, w_putTab;
  logic              r_clrHome, w_clrHome;
  logic [ADDR_W-1:0] r_cnt, w_cnt;
  logic [ADDR_W-1:0] w_cellAddr;

  assign w_cellAddr = ADDR_W'(r_row) * L_COLS_A + ADDR_W'(r_col);
  assign ch_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign cursor_col = r_col;
  assign cursor_row = r_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_ch      <= '0;
      r_putWr   <= 1'b0;
      r_putAdv  <= 1'b0;
      r_putTab  <= 1'b0;
      r_clrHome <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state;
      r_col     <= w_col;
      r_row     <= w_row;
      r_ch      <= w_ch;
      r_putWr   <= w_putWr;
      r_putAdv  <= w_putAdv;
      r_putTab  <= w_putTab;
      r_clrHome <= w_clrHome;
      r_cnt     <= w_cnt;
    end
  end

  // PUT is a one-cycle slot; its flags say whether it writes a cell and whether the cursor then advances.
  always_comb begin
    w_state    = r_state;
    w_col      = r_col;
    w_row      = r_row;
    w_ch       = r_ch;
    w_putWr    = r_putWr;
    w_putAdv   = r_putAdv;
    w_putTab   = r_putTab;
    w_clrHome  = r_clrHome;
    w_cnt      = r_cnt;
    vram_we    = 1'b0;
    vram_waddr = '0;
    vram_wdata = '0;
    vram_raddr = '0;
    case (r_state)
      S_IDLE: begin
        if (ch_valid) begin
          w_state  = S_PUT;
          w_putWr  = 1'b0;
          w_putAdv = 1'b0;
          w_putTab = 1'b0;
          case (ch_data)
            8'h0D: w_col = '0;
            8'h0A: begin
              w_col = '0;
              if (r_row == L_ROW_MAX) begin
                w_state = S_SCROLL_RD;
                w_cnt   = L_COLS_A;
              end else begin
                w_row = r_row + 5'd1;
              end
            end
            8'h08: begin
              if (r_col != 7'd0) begin
                w_col   = r_col - 7'd1;
                w_ch    = L_SPACE;
                w_putWr = 1'b1;
              end
            end
            8'h0C: begin
              w_state   = S_CLEAR;
              w_cnt     = '0;
              w_clrHome = 1'b1;
            end
`ifdef TAB_EXPAND_EN
            8'h09: begin
              w_ch     = L_SPACE;
              w_putWr  = 1'b1;
              w_putAdv = 1'b1;
              w_putTab = 1'b1;
            end
`endif
            default: begin
              w_ch     = ch_data;
              w_putWr  = 1'b1;
              w_putAdv = 1'b1;
            end
          endcase
        end
      end
      S_PUT: begin
        vram_we    = r_putWr;
        vram_waddr = w_cellAddr;
        vram_wdata = DATA_W'(r_ch);
        w_state    = S_IDLE;
        if (r_putAdv) begin
          if (r_col == L_COL_MAX) begin
            w_col = '0;
            if (r_row == L_ROW_MAX) begin
              w_state = S_SCROLL_RD;
              w_cnt   = L_COLS_A;
            end else begin
              w_row = r_row + 5'd1;
            end
          end else begin
            w_col = r_col + 7'd1;
            // A tab keeps writing until the column after this one is a multiple of 8.
            if (r_putTab && (r_col[2:0] != 3'd7)) w_state = S_PUT;
          end
        end
      end
      S_SCROLL_RD: begin
        vram_raddr = r_cnt;
        w_state    = S_SCROLL_WR;
      end
      S_SCROLL_WR: begin
        vram_we    = 1'b1;
        vram_waddr = r_cnt - L_COLS_A;
        vram_wdata = vram_rdata;
        if (r_cnt == L_LAST) begin
          w_state   = S_CLEAR;
          w_cnt     = L_LAST_ROW;
          w_clrHome = 1'b0;
        end else begin
          w_state = S_SCROLL_RD;
          w_cnt   = r_cnt + 1'b1;
        end
      end
      S_CLEAR: begin
        vram_we    = 1'b1;
        vram_waddr = r_cnt;
        vram_wdata = DATA_W'(L_SPACE);
        if (r_cnt == L_LAST) begin
          w_state = S_IDLE;
          if (r_clrHome) begin
            w_col = '0;
            w_row = '0;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Self-checking bench for vga_text_console: VRAM model, table vectors, directed corners and
// random streams against a screen-level reference model. Honours TAB_EXPAND_EN.
module tb_vga_text_console;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic        ch_ready;
  logic        vram_we;
  logic [18:0] vram_waddr;
  logic [11:0] vram_wdata;
  logic [18:0] vram_raddr;
  logic [11:0] vram_rdata = 12'h000;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_text_console dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
    .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  // Synchronous-read VRAM, filled with random glyphs on the first clock.
  logic [11:0] mem [0:CELLS-1];
  logic memInit = 1'b0;
  always @(posedge clk) begin
    int ra, wa;
    if (!memInit) begin
      for (int i = 0; i < CELLS; i++) mem[i] = 12'($urandom_range(32, 126));
      memInit = 1'b1;
    end
    ra = int'(vram_raddr);
    wa = int'(vram_waddr);
    vram_rdata <= (ra < CELLS) ? mem[ra] : 12'h000;
    if (vram_we && wa < CELLS) mem[wa] = vram_wdata;
  end

  // Write log sampled away from the active edge.
  int wrCount = 0;
  int lastAddr = -1;
  int lastData = -1;
  always @(negedge clk) begin
    if (vram_we) begin
      wrCount++;
      lastAddr = int'(vram_waddr);
      lastData = int'(vram_wdata);
    end
  end

  // Screen-level reference model.
  logic [7:0] scr [0:ROWS-1][0:COLS-1];
  int mCol = 0;
  int mRow = 0;

  task automatic modelNewline(output int scrolled);
    scrolled = 0;
    if (mRow < ROWS - 1) mRow++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h20;
      scrolled = 1;
    end
  endtask

  task automatic modelAdvance(output int scrolled);
    scrolled = 0;
    mCol++;
    if (mCol == COLS) begin
      mCol = 0;
      modelNewline(scrolled);
    end
  endtask

  task automatic modelChar(input logic [7:0] ch, output int expBusy, output int expWrites);
    int s;
    expBusy = 1;
    expWrites = 0;
    case (ch)
      8'h0D: mCol = 0;
      8'h0A: begin
        mCol = 0;
        modelNewline(s);
        expBusy = (s != 0) ? 4720 : 1;
        expWrites = s * 2400;
      end
      8'h08: begin
        if (mCol > 0) begin
          mCol--;
          scr[mRow][mCol] = 8'h20;
          expWrites = 1;
        end
      end
      8'h0C: begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
        mCol = 0;
        mRow = 0;
        expBusy = 2400;
        expWrites = 2400;
      end
`ifdef TAB_EXPAND_EN
      8'h09: begin
        expBusy = 0;
        do begin
          scr[mRow][mCol] = 8'h20;
          modelAdvance(s);
          expBusy += 1 + s * 4720;
          expWrites += 1 + s * 2400;
        end while (mCol % 8 != 0);
      end
`endif
      default: begin
        scr[mRow][mCol] = ch;
        modelAdvance(s);
        expBusy = 1 + s * 4720;
        expWrites = 1 + s * 2400;
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic checkVram(input string name);
    int bad = -1;
    for (int i = 0; i < CELLS; i++)
      if (bad < 0 && mem[i] !== {4'h0, scr[i/COLS][i%COLS]}) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("[TB] FAIL %s: cell %0d holds 0x%03h, expected 0x%03h",
               name, bad, mem[bad], {4'h0, scr[bad/COLS][bad%COLS]});
    end
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (!ch_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(ch_ready), 1);
  endtask

  // Offers one byte, then measures busy cycles and VRAM writes for that byte.
  task automatic applyStimulus(input logic [7:0] ch, output int busyCycles, output int writes,
                               output int wAddr, output int wData);
    int start;
    waitReady("ready_before_send");
    start = wrCount;
    ch_valid = 1'b1;
    ch_data = ch;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_data = 8'($urandom);
    busyCycles = 0;
    while (busy && busyCycles < 10000) begin
      busyCycles++;
      @(negedge clk);
    end
    writes = wrCount - start;
    wAddr = (writes > 0) ? lastAddr : -1;
    wData = (writes > 0) ? lastData : -1;
  endtask

  task automatic sendChar(input logic [7:0] ch, input string tag);
    int eb, ew, b, w, a, d;
    modelChar(ch, eb, ew);
    applyStimulus(ch, b, w, a, d);
    checkOutput({tag, "_busy"}, b, eb);
    checkOutput({tag, "_writes"}, w, ew);
    checkOutput({tag, "_col"}, int'(cursor_col), mCol);
    checkOutput({tag, "_row"}, int'(cursor_row), mRow);
  endtask

  function automatic logic [7:0] randPrintable();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == 8'h08 || v == 8'h0A || v == 8'h0C || v == 8'h0D) v = 8'h2A;
    return v;
  endfunction

  typedef struct {
    logic [7:0] ch;
    int col, row, busyC, writes, addr, data;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int eb, ew, b, w, a, d, start, n, r;
    tbl[0]  = '{8'h41, 1, 0, 1, 1, 0, 'h041};
    tbl[1]  = '{8'h42, 2, 0, 1, 1, 1, 'h042};
    tbl[2]  = '{8'h43, 3, 0, 1, 1, 2, 'h043};
`ifdef TAB_EXPAND_EN
    tbl[3]  = '{8'h09, 8, 0, 5, 5, 7, 'h020};
`else
    tbl[3]  = '{8'h09, 4, 0, 1, 1, 3, 'h009};
`endif
    tbl[4]  = '{8'h0D, 0, 0, 1, 0, -1, -1};
    tbl[5]  = '{8'h0A, 0, 1, 1, 0, -1, -1};
    tbl[6]  = '{8'h08, 0, 1, 1, 0, -1, -1};
    tbl[7]  = '{8'h0A, 0, 2, 1, 0, -1, -1};
    tbl[8]  = '{8'h61, 1, 2, 1, 1, 160, 'h061};
    tbl[9]  = '{8'h62, 2, 2, 1, 1, 161, 'h062};
    tbl[10] = '{8'h63, 3, 2, 1, 1, 162, 'h063};
    tbl[11] = '{8'h08, 2, 2, 1, 1, 162, 'h020};
    tbl[12] = '{8'h08, 1, 2, 1, 1, 161, 'h020};
    tbl[13] = '{8'h08, 0, 2, 1, 1, 160, 'h020};
    tbl[14] = '{8'h08, 0, 2, 1, 0, -1, -1};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_we", int'(vram_we), 0);
    checkOutput("rst_waddr", int'(vram_waddr), 0);
    checkOutput("rst_wdata", int'(vram_wdata), 0);
    checkOutput("rst_raddr", int'(vram_raddr), 0);
    checkOutput("rst_col", int'(cursor_col), 0);
    checkOutput("rst_row", int'(cursor_row), 0);
    checkOutput("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", int'(ch_ready), 1);
    for (int i = 0; i < CELLS; i++) scr[i/COLS][i%COLS] = mem[i][7:0];

    // Table vectors: single bytes with hand-derived results.
    for (int i = 0; i < 15; i++) begin
      modelChar(tbl[i].ch, eb, ew);
      applyStimulus(tbl[i].ch, b, w, a, d);
      checkOutput($sformatf("vec%0d_busy", i), b, tbl[i].busyC);
      checkOutput($sformatf("vec%0d_writes", i), w, tbl[i].writes);
      checkOutput($sformatf("vec%0d_addr", i), a, tbl[i].addr);
      checkOutput($sformatf("vec%0d_data", i), d, tbl[i].data);
      checkOutput($sformatf("vec%0d_col", i), int'(cursor_col), tbl[i].col);
      checkOutput($sformatf("vec%0d_row", i), int'(cursor_row), tbl[i].row);
    end
    checkVram("table_vram");

    // LF at the bottom row triggers a full scroll over real screen content.
    for (int i = 0; i < 27; i++) sendChar(8'h0A, "lf_down");
    for (int i = 0; i < 79; i++) sendChar(randPrintable(), "fill_last");
    modelChar(8'h0A, eb, ew);
    applyStimulus(8'h0A, b, w, a, d);
    checkOutput("scroll_busy", b, 4720);
    checkOutput("scroll_writes", w, 2400);
    checkOutput("scroll_last_addr", a, 2399);
    checkOutput("scroll_last_data", d, 'h020);
    checkOutput("scroll_col", int'(cursor_col), 0);
    checkOutput("scroll_row", int'(cursor_row), 29);
    checkVram("scroll_vram");

    // Printable in the bottom-right cell wraps and scrolls.
    for (int i = 0; i < 80; i++) sendChar(randPrintable(), "wrap_scroll");
    checkVram("wrap_scroll_vram");

    // Form feed clears the screen and homes the cursor.
    sendChar(8'h0C, "ff");
    checkOutput("ff_col_home", int'(cursor_col), 0);
    checkVram("ff_vram");

    // Column wrap from (79,5).
    for (int i = 0; i < 5; i++) sendChar(8'h0A, "to_row5");
    for (int i = 0; i < 79; i++) sendChar(8'h78, "to_col79");
    modelChar(8'h42, eb, ew);
    applyStimulus(8'h42, b, w, a, d);
    checkOutput("wrap_addr", a, 479);
    checkOutput("wrap_data", d, 'h042);
    checkOutput("wrap_col", int'(cursor_col), 0);
    checkOutput("wrap_row", int'(cursor_row), 6);

    // Held ch_valid: the busy cycle is ignored and ch_data only counts at transfer.
    waitReady("hold_ready");
    start = wrCount;
    ch_valid = 1'b1;
    ch_data = 8'h51;
    @(negedge clk);
    ch_data = 8'h52;
    repeat (3) @(negedge clk);
    ch_valid = 1'b0;
    waitReady("hold_done");
    modelChar(8'h51, eb, ew);
    modelChar(8'h52, eb, ew);
    checkOutput("hold_writes", wrCount - start, 2);
    checkOutput("hold_col", int'(cursor_col), mCol);
    checkOutput("hold_row", int'(cursor_row), mRow);
    checkVram("hold_vram");

    // Random stream against the reference model.
    sendChar(8'h0C, "ff2");
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      sendChar(randPrintable(), "rnd_glyph");
      else if (r < 81) sendChar(8'h0A, "rnd_lf");
      else if (r < 87) sendChar(8'h0D, "rnd_cr");
      else if (r < 93) sendChar(8'h08, "rnd_bs");
      else if (r < 99) sendChar(8'h09, "rnd_tab");
      else             sendChar(8'h0C, "rnd_ff");
    end
    checkVram("random_vram");

    // Reset during a form-feed clear aborts it at once.
    waitReady("clr_ready");
    ch_valid = 1'b1;
    ch_data = 8'h0C;
    @(negedge clk);
    ch_valid = 1'b0;
    repeat (999) @(negedge clk);
    checkOutput("clr1000_we", int'(vram_we), 1);
    checkOutput("clr1000_addr", int'(vram_waddr), 999);
    checkOutput("clr1000_data", int'(vram_wdata), 'h020);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_we", int'(vram_we), 0);
    checkOutput("abort_col", int'(cursor_col), 0);
    checkOutput("abort_row", int'(cursor_row), 0);
    checkOutput("abort_ready", int'(ch_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    mCol = 0;
    mRow = 0;
    sendChar(8'h0C, "ff_after_abort");
    checkVram("abort_vram");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
